// File: rtl/sd_slot_arbiter.sv
// ---------------------------------------------------------------------------
// sd_slot_arbiter
//
// Shares the single user_io SD block-transfer channel between two sector
// requesters: slot 0 (sd_card SPI emulation) and slot 1 (second disk/NVRAM).
// One transfer runs at a time. The LBA and the operation are latched when the
// grant is given. Ack, buffer-write strobe and write data are routed to and
// from the current owner only. Simultaneous requests are arbitrated
// round-robin.
//
// Ports
//   clk_sys, reset_n      clock, synchronous active-low reset
//   reqN_rd / reqN_wr     level requests from slot N, held until reqN_ack
//   reqN_lba              sector address of slot N
//   reqN_din              buffer data from slot N towards the host
//   reqN_ack              sd_ack gated to slot N
//   reqN_buff_wr          sd_buff_wr gated to slot N
//   reqN_busy             slot N holds the grant
//   reqN_done             one-cycle pulse at the end of a slot N transfer
//   reqN_err              (timeout build only) one-cycle pulse on ack timeout
//   sd_rd / sd_wr         per-slot read/write strobes to user_io
//   sd_lba                latched LBA to user_io
//   sd_din                buffer data to user_io
//   sd_ack, sd_buff_wr    handshake and buffer strobe from user_io
//   grant                 one-hot current owner, 00 when idle
//
// Optional build macro: SD_SLOT_ARB_TIMEOUT_EN adds an ack watchdog of
// TIMEOUT_W bits and the reqN_err outputs.
// ---------------------------------------------------------------------------
module sd_slot_arbiter #(
  parameter int LBA_W     = 32,
  parameter int TIMEOUT_W = 24
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             req0_rd,
  input  logic             req0_wr,
  input  logic [LBA_W-1:0] req0_lba,
  input  logic [7:0]       req0_din,
  output logic             req0_ack,
  output logic             req0_buff_wr,
  output logic             req0_busy,
  output logic             req0_done,
  input  logic             req1_rd,
  input  logic             req1_wr,
  input  logic [LBA_W-1:0] req1_lba,
  input  logic [7:0]       req1_din,
  output logic             req1_ack,
  output logic             req1_buff_wr,
  output logic             req1_busy,
  output logic             req1_done,
`ifdef SD_SLOT_ARB_TIMEOUT_EN
  output logic             req0_err,
  output logic             req1_err,
`endif
  output logic [1:0]       sd_rd,
  output logic [1:0]       sd_wr,
  output logic [LBA_W-1:0] sd_lba,
  output logic [7:0]       sd_din,
  input  logic             sd_ack,
  input  logic             sd_buff_wr,
  output logic [1:0]       grant
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state;
  logic             owner;     // index of the granted slot
  logic             rr_last;   // slot served most recently
  logic [1:0]       done_q;

  logic             want0;
  logic             want1;
  logic             pick;
  logic             pick_rd;
  logic [1:0]       pick_hot;
  logic [LBA_W-1:0] pick_lba;
  logic [1:0]       owner_hot;

  assign want0 = req0_rd | req0_wr;
  assign want1 = req1_rd | req1_wr;

  // With both slots asking, the one not served last wins; otherwise the
  // only asker wins (want1 alone selects slot 1, want0 alone slot 0).
  always_comb begin
    pick = want1;
    if (want0 && want1) begin
      pick = ~rr_last;
    end
    pick_rd  = pick ? req1_rd  : req0_rd;
    pick_lba = pick ? req1_lba : req0_lba;
    pick_hot = pick ? 2'b10 : 2'b01;
  end

  assign owner_hot = owner ? 2'b10 : 2'b01;

`ifdef SD_SLOT_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [1:0]           err_q;

  assign req0_err = err_q[0];
  assign req1_err = err_q[1];
`else
  logic unused_tmo_w;
  assign unused_tmo_w = (TIMEOUT_W > 0);
`endif

  // Arbitration / transfer sequencing
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      grant   <= 2'b00;
      sd_rd   <= 2'b00;
      sd_wr   <= 2'b00;
      sd_lba  <= '0;
      owner   <= 1'b0;
      rr_last <= 1'b1;
      done_q  <= 2'b00;
`ifdef SD_SLOT_ARB_TIMEOUT_EN
      tmo_cnt <= '0;
      err_q   <= 2'b00;
`endif
    end else begin
      done_q <= 2'b00;
`ifdef SD_SLOT_ARB_TIMEOUT_EN
      err_q  <= 2'b00;
`endif
      case (state)
        ST_IDLE: begin
          // sd_ack seen here is spurious and deliberately ignored
          if (want0 || want1) begin
            owner  <= pick;
            grant  <= pick_hot;
            sd_lba <= pick_lba;
            // Read has priority when both rd and wr are raised
            if (pick_rd) begin
              sd_rd <= pick_hot;
            end else begin
              sd_wr <= pick_hot;
            end
`ifdef SD_SLOT_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sd_ack) begin
            sd_rd <= 2'b00;
            sd_wr <= 2'b00;
`ifdef SD_SLOT_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            state <= ST_XFER;
          end
`ifdef SD_SLOT_ARB_TIMEOUT_EN
          else if (&tmo_cnt) begin
            sd_rd   <= 2'b00;
            sd_wr   <= 2'b00;
            done_q  <= owner_hot;
            err_q   <= owner_hot;
            rr_last <= owner;
            grant   <= 2'b00;
            state   <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ST_XFER: begin
          // Falling sd_ack ends the transfer, even if the request was dropped
          if (!sd_ack) begin
            done_q  <= owner_hot;
            rr_last <= owner;
            grant   <= 2'b00;
            state   <= ST_DONE;
          end
`ifdef SD_SLOT_ARB_TIMEOUT_EN
          else if (&tmo_cnt) begin
            done_q  <= owner_hot;
            err_q   <= owner_hot;
            rr_last <= owner;
            grant   <= 2'b00;
            state   <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Combinational routing to the current owner
  assign req0_ack     = sd_ack & grant[0];
  assign req1_ack     = sd_ack & grant[1];
  assign req0_buff_wr = sd_buff_wr & grant[0];
  assign req1_buff_wr = sd_buff_wr & grant[1];
  assign req0_busy    = grant[0];
  assign req1_busy    = grant[1];
  assign req0_done    = done_q[0];
  assign req1_done    = done_q[1];

  always_comb begin
    sd_din = 8'h00;
    if (grant[0]) begin
      sd_din = req0_din;
    end else if (grant[1]) begin
      sd_din = req1_din;
    end
  end

endmodule

// File: tb/tb_sd_slot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sd_slot_arbiter
//
// Directed vector table, hand-written multi-cycle sequences and a random
// phase checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_sd_slot_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        req0_rd, req0_wr, req1_rd, req1_wr;
  logic [31:0] req0_lba, req1_lba;
  logic [7:0]  req0_din, req1_din;
  logic        req0_ack, req0_buff_wr, req0_busy, req0_done;
  logic        req1_ack, req1_buff_wr, req1_busy, req1_done;
  logic [1:0]  sd_rd, sd_wr, grant;
  logic [31:0] sd_lba;
  logic [7:0]  sd_din;
  logic        sd_ack, sd_buff_wr;
`ifdef SD_SLOT_ARB_TIMEOUT_EN
  logic        req0_err, req1_err;
`endif

  sd_slot_arbiter #(.LBA_W(32), .TIMEOUT_W(24)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .req0_rd(req0_rd), .req0_wr(req0_wr), .req0_lba(req0_lba), .req0_din(req0_din),
    .req0_ack(req0_ack), .req0_buff_wr(req0_buff_wr), .req0_busy(req0_busy), .req0_done(req0_done),
    .req1_rd(req1_rd), .req1_wr(req1_wr), .req1_lba(req1_lba), .req1_din(req1_din),
    .req1_ack(req1_ack), .req1_buff_wr(req1_buff_wr), .req1_busy(req1_busy), .req1_done(req1_done),
`ifdef SD_SLOT_ARB_TIMEOUT_EN
    .req0_err(req0_err), .req1_err(req1_err),
`endif
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba), .sd_din(sd_din),
    .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr), .grant(grant)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: owner slot (-1 idle), whether the strobe is still
  // outstanding, a one-cycle gap after completion, last served slot.
  int         m_owner;
  bit         m_strobe, m_isrd, m_gap, m_last;
  bit [1:0]   m_done;
  logic [31:0] m_lba;

  task automatic model_step();
    int pick;
    bit r0, r1;
    if (!reset_n) begin
      m_owner = -1; m_strobe = 0; m_gap = 0; m_last = 1; m_done = 0; m_lba = 0; m_isrd = 0;
    end else begin
      m_done = 0;
      if (m_gap) begin
        m_gap = 0;
      end else if (m_owner < 0) begin
        r0 = req0_rd | req0_wr;
        r1 = req1_rd | req1_wr;
        pick = -1;
        if (r0 && r1) pick = m_last ? 0 : 1;
        else if (r0)  pick = 0;
        else if (r1)  pick = 1;
        if (pick >= 0) begin
          m_owner  = pick;
          m_strobe = 1;
          m_isrd   = (pick == 0) ? req0_rd : req1_rd;
          m_lba    = (pick == 0) ? req0_lba : req1_lba;
        end
      end else if (m_strobe) begin
        if (sd_ack) m_strobe = 0;
      end else if (!sd_ack) begin
        m_done[m_owner] = 1;
        m_last  = (m_owner == 1);
        m_owner = -1;
        m_gap   = 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [1:0] eg, erd, ewr;
    logic [7:0] ed;
    eg  = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    erd = (m_strobe && m_isrd)  ? eg : 2'b00;
    ewr = (m_strobe && !m_isrd) ? eg : 2'b00;
    ed  = (m_owner == 0) ? req0_din : ((m_owner == 1) ? req1_din : 8'h00);
    chk({tag, "/ctl"},
        {grant, sd_rd, sd_wr, req1_done, req0_done, req1_busy, req0_busy,
         req1_ack, req0_ack, req1_buff_wr, req0_buff_wr},
        {eg, erd, ewr, m_done, eg, {sd_ack, sd_ack} & eg, {sd_buff_wr, sd_buff_wr} & eg});
    chk({tag, "/lba"}, sd_lba, m_lba);
    chk({tag, "/din"}, sd_din, ed);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk_sys);
    model_step();
    #1;
    check_model(tag);
  endtask

  typedef struct {
    bit          rn, rd0, wr0, rd1, wr1, ack;
    logic [1:0]  e_grant, e_rd, e_wr, e_done, e_ack;
    logic [31:0] e_lba;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rn, input bit rd0, input bit wr0, input bit rd1, input bit wr1,
                     input bit ack, input logic [1:0] g, input logic [1:0] rd, input logic [1:0] wr,
                     input logic [1:0] dn, input logic [1:0] ak, input logic [31:0] lba);
    vec_t v;
    v.rn = rn; v.rd0 = rd0; v.wr0 = wr0; v.rd1 = rd1; v.wr1 = wr1; v.ack = ack;
    v.e_grant = g; v.e_rd = rd; v.e_wr = wr; v.e_done = dn; v.e_ack = ak; v.e_lba = lba;
    vecs.push_back(v);
  endtask

  task automatic clear_inputs();
    req0_rd = 0; req0_wr = 0; req1_rd = 0; req1_wr = 0;
    sd_ack = 0; sd_buff_wr = 0;
  endtask

  logic [1:0] alt_seq[4];
  int         alt_n;
  logic [1:0] prev_grant;
  int         cnt0, cnt1;

  initial begin
    reset_n = 0;
    clear_inputs();
    req0_lba = 32'h0000_1234; req1_lba = 32'h0000_BEEF;
    req0_din = 8'h00; req1_din = 8'h00;

    // rn rd0 wr0 rd1 wr1 ack | grant rd wr done ack lba
    add(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 32'h0);      // reset state
    add(1,1,0,0,0,0, 2'b01,2'b01,2'b00,2'b00,2'b00, 32'h1234);   // slot0 read granted
    add(1,1,0,0,0,0, 2'b01,2'b01,2'b00,2'b00,2'b00, 32'h1234);
    add(1,1,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,2'b01, 32'h1234);   // ack rise clears rd
    add(1,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,2'b01, 32'h1234);
    add(1,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,2'b01, 32'h1234);
    add(1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b01,2'b00, 32'h1234);   // done0 pulse
    add(1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 32'h1234);
    add(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 32'h0);      // reset again
    add(1,0,1,0,1,0, 2'b01,2'b00,2'b01,2'b00,2'b00, 32'h1234);   // both write, slot0 first
    add(1,0,1,0,1,1, 2'b01,2'b00,2'b00,2'b00,2'b01, 32'h1234);
    add(1,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b01,2'b00, 32'h1234);
    add(1,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 32'h1234);   // DONE gap
    add(1,0,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 32'hBEEF);   // slot1 write
    add(1,0,0,0,0,1, 2'b10,2'b00,2'b00,2'b00,2'b10, 32'hBEEF);
    add(1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b10,2'b00, 32'hBEEF);
    add(1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 32'hBEEF);
    add(1,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b00, 32'hBEEF);   // spurious ack in idle
    add(1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 32'hBEEF);
    add(1,1,1,0,0,0, 2'b01,2'b01,2'b00,2'b00,2'b00, 32'h1234);   // rd+wr: read wins
    add(1,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,2'b01, 32'h1234);
    add(1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b01,2'b00, 32'h1234);
    add(1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 32'h1234);

    for (int i = 0; i < vecs.size(); i++) begin
      reset_n = vecs[i].rn;
      req0_rd = vecs[i].rd0; req0_wr = vecs[i].wr0;
      req1_rd = vecs[i].rd1; req1_wr = vecs[i].wr1;
      sd_ack  = vecs[i].ack;
      @(posedge clk_sys);
      model_step();
      #1;
      chk($sformatf("vec%0d/ctl", i), {grant, sd_rd, sd_wr, req1_done, req0_done, req1_ack, req0_ack},
          {vecs[i].e_grant, vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_done, vecs[i].e_ack});
      chk($sformatf("vec%0d/lba", i), sd_lba, vecs[i].e_lba);
    end

    // Alternation with both slots requesting continuously
    clear_inputs(); reset_n = 0; cycle("alt_rst"); reset_n = 1;
    req0_rd = 1; req1_rd = 1;
    alt_n = 0; prev_grant = 2'b00;
    for (int c = 0; c < 200 && alt_n < 4; c++) begin
      sd_ack = (sd_rd != 2'b00) || (sd_wr != 2'b00);
      cycle("alt");
      if (prev_grant == 2'b00 && grant != 2'b00) begin
        alt_seq[alt_n] = grant;
        alt_n++;
      end
      prev_grant = grant;
    end
    chk("alt/count", alt_n, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < alt_n) chk($sformatf("alt/grant%0d", k), alt_seq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Slot-1 write with 512 buffer strobes while slot 0 waits
    clear_inputs(); reset_n = 0; cycle("buf_rst"); reset_n = 1;
    req0_din = 8'h3C; req1_din = 8'hA5; req1_wr = 1;
    cycle("buf_grant");
    chk("buf/grant", grant, 2'b10);
    req1_wr = 0; req0_rd = 1; sd_ack = 1;
    cycle("buf_xfer");
    cnt0 = 0; cnt1 = 0;
    for (int p = 0; p < 512; p++) begin
      sd_buff_wr = 1;
      cycle("buf_hi");
      cnt0 += req0_buff_wr; cnt1 += req1_buff_wr;
      if (p == 0) chk("buf/din", sd_din, 8'hA5);
      sd_buff_wr = 0;
      cycle("buf_lo");
      cnt0 += req0_buff_wr; cnt1 += req1_buff_wr;
    end
    chk("buf/req1_pulses", cnt1, 512);
    chk("buf/req0_pulses", cnt0, 0);
    sd_ack = 0;
    cycle("buf_done");
    chk("buf/done1", req1_done, 1'b1);
    cycle("buf_gap");
    cycle("buf_next");
    chk("buf/next_grant", grant, 2'b01);
    sd_ack = 1; req0_rd = 0; cycle("buf_next_ack");
    sd_ack = 0; cycle("buf_next_done"); cycle("buf_next_gap");

    // Reset in the middle of a transfer, then a fresh grant
    clear_inputs(); reset_n = 0; cycle("mid_rst0"); reset_n = 1;
    req0_rd = 1; req0_lba = 32'hCAFE_0001; cycle("mid_grant");
    sd_ack = 1; cycle("mid_xfer");
    req0_rd = 0; reset_n = 0; cycle("mid_rst");
    chk("mid/after_reset", {grant, sd_rd, sd_wr, req1_done, req0_done}, 8'h00);
    reset_n = 1; sd_ack = 0; req1_rd = 1; req1_lba = 32'h0BAD_F00D;
    cycle("mid_regrant");
    chk("mid/regrant", {grant, sd_rd}, 4'b1010);
    req1_rd = 0; sd_ack = 1; cycle("mid_ack");
    sd_ack = 0; cycle("mid_done"); cycle("mid_gap");

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset_n    = ($urandom_range(0, 199) != 0);
      req0_rd    = ($urandom_range(0, 3) == 0);
      req0_wr    = ($urandom_range(0, 3) == 0);
      req1_rd    = ($urandom_range(0, 3) == 0);
      req1_wr    = ($urandom_range(0, 3) == 0);
      sd_ack     = ($urandom_range(0, 2) != 0);
      sd_buff_wr = $urandom_range(0, 1);
      req0_lba   = $urandom;
      req1_lba   = $urandom;
      req0_din   = 8'($urandom);
      req1_din   = 8'($urandom);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
